// File: rtl/grf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : grf_pkg
// Brief    : Shared types, constants and the byte-merge helper for the
//            multi-port general register file with busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package grf_pkg;

    // Widest register the merge helper handles; callers zero-extend into it
    // and truncate the result back to their own DATA_W.
    localparam int c_max_data_w = 256;
    localparam int c_max_be_w   = c_max_data_w / 8;

    // Format of the committed-write trace line: pc, register number, word.
    localparam string c_trace_fmt = "@%h: $%d <= %h";

    // Sweep-clear engine states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

    // Byte i of the result comes from new_word where be[i] is set and from
    // old_word otherwise. Shared by the array write and the read bypass so
    // that both always agree on the merged value.
    function automatic logic [c_max_data_w-1:0] merge_bytes(
        input logic [c_max_data_w-1:0] old_word,
        input logic [c_max_data_w-1:0] new_word,
        input logic [c_max_be_w-1:0]   be
    );
        logic [c_max_data_w-1:0] merged;
        merged = old_word;
        for (int i = 0; i < c_max_be_w; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/grf_multiport_sb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : grf_scoreboard
// Brief    : One busy bit per register. Issue sets, committed write clears,
//            set wins on a same-cycle collision; the sweep engine clears one
//            entry per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module grf_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_set_en,
    input  logic [ADDR_W-1:0]    i_set_addr,
    input  logic                 i_clr_en,
    input  logic [ADDR_W-1:0]    i_clr_addr,
    input  logic                 i_sweep_en,
    input  logic [ADDR_W-1:0]    i_sweep_addr,
    output logic [2**ADDR_W-1:0] o_busy
);

    logic [2**ADDR_W-1:0] r_busy;

    // Busy bits; later assignments take priority, so set beats clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            if (i_sweep_en) begin
                r_busy[i_sweep_addr] <= 1'b0;
            end
            if (i_clr_en) begin
                r_busy[i_clr_addr] <= 1'b0;
            end
            if (i_set_en) begin
                r_busy[i_set_addr] <= 1'b1;
            end
        end
    end

    assign o_busy = r_busy;

endmodule
`default_nettype wire

// File: rtl/grf_multiport_sb.sv
`default_nettype none
// ============================================================================
// Module   : grf_multiport_sb
// Brief    : Parametrised general register file with NUM_RD combinational
//            read ports, byte-enable writes, same-cycle write-to-read bypass,
//            a per-register busy scoreboard and a sequential sweep-clear.
// Revision : 1.0 - initial release
// ============================================================================
module grf_multiport_sb
    import grf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int TRACE    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              pc,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W/8-1:0]      wbe,
    input  logic [DATA_W-1:0]        wd,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     ready
);

    localparam int DEPTH = 2**ADDR_W;

    sweep_state_t      r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_regs [DEPTH];

    logic              w_sweeping;
    logic              w_wa_ok;
    logic              w_iss_ok;
    logic              w_commit;
    logic              w_issue;
    logic [DATA_W-1:0] w_merged;
    logic [DEPTH-1:0]  w_busy;

    // Register 0 is hard-wired only when ZERO_REG is set.
    assign w_sweeping = (r_state == SWEEP);
    assign clr_busy   = w_sweeping;
    assign ready      = ~w_sweeping;
    assign w_wa_ok    = (ZERO_REG == 0) || (wa != '0);
    assign w_iss_ok   = (ZERO_REG == 0) || (iss_addr != '0);
    assign w_commit   = we & ready & w_wa_ok;
    assign w_issue    = iss_valid & ready & w_iss_ok;

    // Merged word: feeds both the array write and the read bypass.
    assign w_merged = DATA_W'(merge_bytes(c_max_data_w'(r_regs[wa]),
                                          c_max_data_w'(wd),
                                          c_max_be_w'(wbe)));

    // Data array: sweep clears one entry per cycle, otherwise commit a write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_sweeping) begin
            r_regs[r_ptr] <= '0;
        end else if (w_commit) begin
            r_regs[wa] <= w_merged;
        end
    end

    // Sweep FSM: IDLE waits for clr_req, SWEEP visits every entry once and
    // leaves after the last one; the pointer wraps back to 0 on exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clr_req) begin
                        r_state <= SWEEP;
                        r_ptr   <= '0;
                    end
                end
                SWEEP: begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                    if (&r_ptr) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    grf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .i_set_en     (w_issue),
        .i_set_addr   (iss_addr),
        .i_clr_en     (w_commit),
        .i_clr_addr   (wa),
        .i_sweep_en   (w_sweeping),
        .i_sweep_addr (r_ptr),
        .o_busy       (w_busy)
    );

    // Read ports: forced to zero while sweeping or when reading the hard-wired
    // zero register; a same-cycle commit to the read address is bypassed.
    // The scoreboard is shown as registered, without bypass.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_ra_zero;
        logic              w_hit;

        assign w_ra      = ra[k*ADDR_W +: ADDR_W];
        assign w_ra_zero = (ZERO_REG != 0) && (w_ra == '0);
        assign w_hit     = w_commit && (wa == w_ra);

        assign rd[k*DATA_W +: DATA_W] = (w_sweeping || w_ra_zero) ? '0 :
                                        w_hit                    ? w_merged :
                                                                   r_regs[w_ra];
        assign rd_busy[k] = ~w_sweeping & w_busy[w_ra];
    end

    if (TRACE != 0) begin : g_trace
        // Print every committed write with the merged full word.
        always @(posedge clk) begin
            if (reset && w_commit) begin
                $display(c_trace_fmt, pc, wa, w_merged);
            end
        end
    end else begin : g_no_trace
        logic w_unused_pc;
        assign w_unused_pc = ^pc;
    end

endmodule
`default_nettype wire
